// File: rtl/csd_pkg.sv
// csd_pkg: shared definitions for the CSD encoder.
//   CSD_POS / CSD_ZERO / CSD_NEG : 8-bit digit codes written to the CSD memory
//   csd_state_e                  : encoder FSM states
//   CSD_ADDR_W                   : default memory address width
package csd_pkg;

  localparam int CSD_ADDR_W = 4;

  localparam logic [7:0] CSD_POS  = 8'h01;
  localparam logic [7:0] CSD_ZERO = 8'h00;
  localparam logic [7:0] CSD_NEG  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } csd_state_e;

endpackage

// File: rtl/csd_digit_cell.sv
// csd_digit_cell: one step of the LSB-first binary-to-CSD recoding.
// Ports:
//   b         in   current binary bit
//   n         in   next (more significant) binary bit
//   carry_in  in   carry from the previous digit
//   digit     out  digit code (CSD_POS / CSD_ZERO / CSD_NEG)
//   carry_out out  carry into the next digit
module csd_digit_cell
  import csd_pkg::*;
(
  input  logic       b,
  input  logic       n,
  input  logic       carry_in,
  output logic [7:0] digit,
  output logic       carry_out
);

  logic [1:0] x;

  assign x = {1'b0, b} + {1'b0, carry_in};

  always_comb begin
    digit     = CSD_ZERO;
    carry_out = 1'b0;
    case (x)
      2'd1: begin
        // An isolated 1 stays +1; a 1 that starts a run becomes -1 with a carry.
        if (n) begin
          digit     = CSD_NEG;
          carry_out = 1'b1;
        end else begin
          digit     = CSD_POS;
        end
      end
      2'd2: carry_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/csd_encoder.sv
// csd_encoder: converts an unsigned WIDTH-bit word into WIDTH+1 CSD digits,
// LSB first, writing one 8-bit digit per clock into the CSD memory.
// Requires WIDTH+1 <= 2**ADDR_W and WIDTH >= 2.
// Optional build macro: CSD_NZ_COUNT_EN (enables the nonzero-digit counter;
// when undefined nz_count is tied to 0).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   conversion request, sampled only in IDLE
//   bin_in     in   value to encode, captured on an accepted start
//   busy       out  conversion in progress (write cycles)
//   we_out     out  memory write enable, one cycle per digit
//   addr_out   out  digit index / memory address
//   digit_out  out  digit code (01 = +1, 00 = 0, FF = -1)
//   done       out  one-cycle pulse after the last digit write
//   nz_count   out  number of nonzero digits of the last conversion
//
// state | meaning
// IDLE  | waiting for start; digit 0 is produced on the accepting edge
// CONV  | one digit written per cycle, addr_out = digit index
// DONE  | single done cycle, then back to IDLE
module csd_encoder
  import csd_pkg::*;
#(
  parameter int WIDTH  = 15,
  parameter int ADDR_W = CSD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin_in,
  output logic              busy,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [7:0]        digit_out,
  output logic              done,
  output logic [4:0]        nz_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH);

  csd_state_e        state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        digit_q, digit_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  logic              cell_b, cell_n, cell_cin, cell_cout;
  logic [7:0]        cell_digit;

  assign accept = (state_q == IDLE) && start;

  // Outputs are registered, so digit 0 must be computed straight from bin_in
  // on the accepting edge; later digits come from the shift register, whose
  // bit 0 is always the next digit's operand. Zeros shift in from the top.
  assign cell_b   = (state_q == IDLE) ? bin_in[0] : sh_q[0];
  assign cell_n   = (state_q == IDLE) ? bin_in[1] : sh_q[1];
  assign cell_cin = (state_q == IDLE) ? 1'b0      : carry_q;

  csd_digit_cell u_cell (
    .b         (cell_b),
    .n         (cell_n),
    .carry_in  (cell_cin),
    .digit     (cell_digit),
    .carry_out (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    carry_d = carry_q;
    addr_d  = addr_q;
    digit_d = digit_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          sh_d    = bin_in >> 1;
          carry_d = cell_cout;
          addr_d  = '0;
          digit_d = cell_digit;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        if (addr_q == LAST_IDX) begin
          // Carry is provably 0 here, so no extra digit is needed.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          sh_d    = sh_q >> 1;
          carry_d = cell_cout;
          addr_d  = addr_q + ADDR_W'(1);
          digit_d = cell_digit;
          we_d    = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      carry_q <= 1'b0;
      addr_q  <= '0;
      digit_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      carry_q <= carry_d;
      addr_q  <= addr_d;
      digit_q <= digit_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign we_out    = we_q;
  assign addr_out  = addr_q;
  assign digit_out = digit_q;
  assign done      = done_q;

`ifdef CSD_NZ_COUNT_EN
  logic [4:0] nz_q;
  logic       nz_hit;

  assign nz_hit = we_d && (digit_d != CSD_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_q <= '0;
    end else if (accept) begin
      nz_q <= {4'd0, nz_hit};
    end else if (nz_hit) begin
      nz_q <= nz_q + 5'd1;
    end
  end

  assign nz_count = nz_q;
`else
  assign nz_count = '0;
`endif

endmodule

// File: tb/tb_csd_encoder.sv
module tb_csd_encoder;

  localparam int WIDTH  = 15;
  localparam int ADDR_W = 4;
  localparam int NDIG   = WIDTH + 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  bin_in;
  logic              busy;
  logic              we_out;
  logic [ADDR_W-1:0] addr_out;
  logic [7:0]        digit_out;
  logic              done;
  logic [4:0]        nz_count;

  int checks;
  int errors;

  int exp_dig [NDIG];
  int exp_nz;

  csd_encoder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .we_out    (we_out),
    .addr_out  (addr_out),
    .digit_out (digit_out),
    .done      (done),
    .nz_count  (nz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Non-adjacent form by arithmetic: an odd residue v picks d = +1 if v mod 4
  // is 1, else -1, then v <- (v - d) / 2. Digit codes are the memory bytes.
  function automatic void csd_model(input int v);
    int vv;
    vv = v;
    exp_nz = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (vv % 2 == 1) begin
        if (vv % 4 == 1) begin
          exp_dig[i] = 8'h01;
          vv = vv - 1;
        end else begin
          exp_dig[i] = 8'hFF;
          vv = vv + 1;
        end
        exp_nz++;
      end else begin
        exp_dig[i] = 8'h00;
      end
      vv = vv / 2;
    end
  endfunction

  function automatic int nz_expected();
`ifdef CSD_NZ_COUNT_EN
    return exp_nz;
`else
    return 0;
`endif
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // done cycle. With hold set, start stays asserted throughout.
  task automatic run_conv(input logic [WIDTH-1:0] v, input bit hold);
    csd_model(int'(v));
    bin_in = v;
    start  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      bin_in = WIDTH'($urandom);
      chk("we", int'(we_out), 1);
      chk("addr", int'(addr_out), i);
      chk($sformatf("digit[%0d] v=%0h", i, v), int'(digit_out), exp_dig[i]);
      chk("busy", int'(busy), 1);
      chk("done_early", int'(done), 0);
    end
    @(negedge clk);
    chk("done", int'(done), 1);
    chk("we_in_done", int'(we_out), 0);
    chk("busy_in_done", int'(busy), 0);
    chk("addr_hold", int'(addr_out), WIDTH);
    chk("digit_hold", int'(digit_out), exp_dig[NDIG-1]);
    chk($sformatf("nz v=%0h", v), int'(nz_count), nz_expected());
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_done", int'(done), 0);
      chk("idle_we", int'(we_out), 0);
      chk("idle_nz", int'(nz_count), nz_expected());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(we_out), 0);
    chk("rst_addr", int'(addr_out), 0);
    chk("rst_digit", int'(digit_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_nz", int'(nz_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner values.
    run_conv(15'd7, 1'b0);     idle_check(2);
    run_conv(15'h7FFF, 1'b0);  idle_check(1);
    run_conv(15'h5555, 1'b0);  idle_check(1);
    run_conv(15'h0000, 1'b0);  idle_check(1);
    run_conv(15'h2AAA, 1'b0);  idle_check(1);

    // Reset in the middle of a conversion (during the i=5 write).
    bin_in = 15'h1234;
    start  = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_addr", int'(addr_out), 5);
    reset = 1'b1;
    #1;
    chk("abort_we", int'(we_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(addr_out), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      chk("abort_no_we", int'(we_out), 0);
    end
    run_conv(15'd7, 1'b0);
    idle_check(1);

    // start held: second conversion only after the post-done idle cycle.
    run_conv(15'd3, 1'b1);
    @(negedge clk);
    chk("held_gap_we", int'(we_out), 0);
    chk("held_gap_busy", int'(busy), 0);
    chk("held_gap_done", int'(done), 0);
    run_conv(15'd3, 1'b1);
    start = 1'b0;
    @(negedge clk);
    // Start was still high in the done cycle but must not be queued.
    chk("no_queue_we", int'(we_out), 0);
    idle_check(2);

    // Random values with random idle gaps.
    for (int t = 0; t < 25; t++) begin
      run_conv(WIDTH'($urandom_range(0, 32767)), 1'b0);
      idle_check(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
